gray_decode_tracker: RTL and testbench

GRAY_DECODE_TRACKER -- requirements
Module: gray_decode_tracker

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray_sync.sv | 36 +++
 rtl/gray_decode_tracker.sv | 102 ++++++++++
 tb/tb_gray_decode_tracker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code tracker family.
//   GRAY_WIDTH   : default Gray/binary width
//   GRAY_MAX_W   : widest value the decode helper accepts
//   ERR_CNT_W    : width of the illegal-step counter
//   ERR_CNT_MAX  : saturation value of that counter
//   gray_to_bin(): Gray-to-binary decode, usable by RTL and by the encoder bench
package gray_pkg;

    localparam int GRAY_WIDTH = 3;
    localparam int GRAY_MAX_W = 32;
    localparam int ERR_CNT_W  = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Works on a zero-extended operand: leading zero Gray bits decode to
    // leading zero binary bits, so callers slice off the width they need.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into clk.
// Ports:
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   raw    : Gray value from the foreign domain
//   synced : value after SYNC_STAGES flops (legal range 2..4)
module gray_sync #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // Pure flop chain: nothing combinational between stages so metastability
    // has a full cycle to resolve at each hop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign synced = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_decode_tracker.sv
// Synchronizes an asynchronous Gray-coded position, decodes it to binary and
// classifies each change as a legal single step (up/down, with wrap) or an
// illegal multi-step jump.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   gray_in   : Gray-coded input, asynchronous to clk
//   clr_err   : synchronous clear of err_flag / err_cnt
//   bin_out   : registered binary position
//   bin_valid : one-cycle pulse on a legal single step
//   dir       : direction of the last legal step (1 = up)
//   step_err  : one-cycle pulse on an illegal jump
//   err_flag  : sticky error indicator
//   err_cnt   : saturating count of illegal jumps
module gray_decode_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 dir,
    output logic                 step_err,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 1'b1;
    endfunction

    // ---- stage p0: synchronized Gray value and its combinational decode ----
    logic [WIDTH-1:0]      gray_p0;
    logic [GRAY_MAX_W-1:0] dec_full_p0;
    logic [WIDTH-1:0]      dec_p0;
    logic [WIDTH-1:0]      delta_p0;
    logic                  up_p0;
    logic                  down_p0;
    logic                  illegal_p0;

    gray_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (gray_in),
        .synced (gray_p0)
    );

    assign dec_full_p0 = gray_to_bin(GRAY_MAX_W'(gray_p0));
    assign dec_p0      = dec_full_p0[WIDTH-1:0];

    generate
        if (WIDTH < GRAY_MAX_W) begin : g_dec_hi
            logic unused_dec_hi;
            assign unused_dec_hi = ^dec_full_p0[GRAY_MAX_W-1:WIDTH];
        end
    endgenerate

    // Modular subtraction makes wrap-around (max->0, 0->max) fall out as +1 / -1.
    assign delta_p0   = dec_p0 - bin_out;
    assign up_p0      = (delta_p0 == WIDTH'(1));
    assign down_p0    = (delta_p0 == {WIDTH{1'b1}}) && !up_p0;
    assign illegal_p0 = (delta_p0 != '0) && !up_p0 && !down_p0;

    // ---- stage p1: registered position, pulses and error bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out   <= '0;
            bin_valid <= 1'b0;
            dir       <= 1'b0;
            step_err  <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            bin_out   <= dec_p0;
            bin_valid <= up_p0 || down_p0;
            step_err  <= illegal_p0;
            if (up_p0) begin
                dir <= 1'b1;
            end else if (down_p0) begin
                dir <= 1'b0;
            end
            // A jump coinciding with a clear wins: the clear wipes history,
            // the new jump is recorded as the first event.
            if (clr_err) begin
                err_flag <= illegal_p0;
                err_cnt  <= illegal_p0 ? ERR_CNT_W'(1) : '0;
            end else if (illegal_p0) begin
                err_flag <= 1'b1;
                err_cnt  <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_gray_decode_tracker.sv
module tb_gray_decode_tracker;

    logic       clk;
    logic       rst_n;
    logic [2:0] gray_in;
    logic       clr_err;
    logic [2:0] bin_out;
    logic       bin_valid;
    logic       dir;
    logic       step_err;
    logic       err_flag;
    logic [7:0] err_cnt;

    int n_cmp;
    int n_mis;
    int vld_pulses;
    int err_pulses;
    int both_cnt;

    gray_decode_tracker #(
        .WIDTH       (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .dir       (dir),
        .step_err  (step_err),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bin_valid) vld_pulses++;
        if (step_err) err_pulses++;
        if (bin_valid && step_err) both_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".bin_out"},   32'(bin_out),   32'd0);
        check_val({tag, ".bin_valid"}, 32'(bin_valid), 32'd0);
        check_val({tag, ".dir"},       32'(dir),       32'd0);
        check_val({tag, ".step_err"},  32'(step_err),  32'd0);
        check_val({tag, ".err_flag"},  32'(err_flag),  32'd0);
        check_val({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    // Called at a negedge; result is visible after the third rising edge,
    // and the next change follows five cycles after this one.
    task automatic step(input logic [2:0] g, input logic [2:0] eb, input logic ev,
                        input logic ed, input logic ee, input string tag);
        gray_in = g;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_val({tag, ".bin"}, 32'(bin_out),   32'(eb));
        check_val({tag, ".vld"}, 32'(bin_valid), 32'(ev));
        check_val({tag, ".dir"}, 32'(dir),       32'(ed));
        check_val({tag, ".err"}, 32'(step_err),  32'(ee));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] up_gray [8];
        logic [2:0] up_bin  [8];
        n_cmp = 0; n_mis = 0;
        vld_pulses = 0; err_pulses = 0; both_cnt = 0;
        up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        up_bin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset with a nonzero input: everything stays at zero.
        rst_n = 1'b0; gray_in = 3'b110; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");

        // Release with 001: legal up step lands on the third edge.
        gray_in = 3'b001;
        rst_n   = 1'b1;
        @(negedge clk);
        check_val("rel.e1.vld", 32'(bin_valid), 32'd0);
        @(negedge clk);
        check_val("rel.e2.bin", 32'(bin_out), 32'd0);
        check_val("rel.e2.vld", 32'(bin_valid), 32'd0);
        @(negedge clk);
        check_val("rel.e3.bin", 32'(bin_out),   32'd1);
        check_val("rel.e3.vld", 32'(bin_valid), 32'd1);
        check_val("rel.e3.dir", 32'(dir),       32'd1);
        check_val("rel.e3.err", 32'(step_err),  32'd0);
        @(negedge clk);
        check_val("rel.e4.vld", 32'(bin_valid), 32'd0);
        repeat (2) @(negedge clk);

        step(3'b000, 3'd0, 1'b1, 1'b0, 1'b0, "home");

        // Up sweep 0..7 then wrap to 0.
        vld_pulses = 0; err_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(up_gray[i], up_bin[i], 1'b1, 1'b1, 1'b0, $sformatf("up%0d", i));
        end
        check_val("up.pulses", 32'(vld_pulses), 32'd8);
        check_val("up.errs",   32'(err_pulses), 32'd0);

        // Down sweep 0 -> 7 (wrap) .. 0.
        vld_pulses = 0; err_pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            step(up_gray[i], up_bin[i], 1'b1, 1'b0, 1'b0, $sformatf("dn%0d", i));
        end
        step(3'b000, 3'd0, 1'b1, 1'b0, 1'b0, "dn_last");
        check_val("dn.pulses", 32'(vld_pulses), 32'd8);
        check_val("dn.errs",   32'(err_pulses), 32'd0);
        check_val("dn.flag",   32'(err_flag),   32'd0);

        // Illegal jump 0 -> 3.
        step(3'b010, 3'd3, 1'b0, 1'b0, 1'b1, "jump");
        check_val("jump.flag", 32'(err_flag), 32'd1);
        check_val("jump.cnt",  32'(err_cnt),  32'd1);

        // 300 more alternating jumps: counter pins at 255.
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 3'b000 : 3'b010;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_val("sat.pulses", 32'(err_pulses), 32'd300);
        check_val("sat.cnt",    32'(err_cnt),    32'd255);
        check_val("sat.flag",   32'(err_flag),   32'd1);
        check_val("sat.bin",    32'(bin_out),    32'd3);

        // Clear in the same cycle as a jump 3 -> 0.
        gray_in = 3'b000;
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_val("clrjmp.cnt",  32'(err_cnt),  32'd1);
        check_val("clrjmp.flag", 32'(err_flag), 32'd1);
        check_val("clrjmp.err",  32'(step_err), 32'd1);
        check_val("clrjmp.bin",  32'(bin_out),  32'd0);
        repeat (2) @(negedge clk);

        // Plain clear.
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_val("clr.cnt",  32'(err_cnt),  32'd0);
        check_val("clr.flag", 32'(err_flag), 32'd0);
        repeat (2) @(negedge clk);

        // Walk up to 5, then reset asynchronously with a new value in flight.
        for (int i = 0; i < 5; i++) begin
            step(up_gray[i], up_bin[i], 1'b1, 1'b1, 1'b0, $sformatf("walk%0d", i));
        end
        check_val("walk.bin", 32'(bin_out), 32'd5);
        gray_in = 3'b101;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        gray_in = 3'b001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post.e1.vld", 32'(bin_valid), 32'd0);
        check_val("post.e1.err", 32'(step_err),  32'd0);
        @(negedge clk);
        check_val("post.e2.bin", 32'(bin_out), 32'd0);
        @(negedge clk);
        check_val("post.e3.bin", 32'(bin_out),   32'd1);
        check_val("post.e3.vld", 32'(bin_valid), 32'd1);
        check_val("post.e3.dir", 32'(dir),       32'd1);
        check_val("post.e3.err", 32'(step_err),  32'd0);
        check_val("post.e3.cnt", 32'(err_cnt),   32'd0);
        repeat (2) @(negedge clk);

        check_val("exclusive", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
